adder16_rr_arbiter: RTL and testbench

Round-robin arbiter and 2-stage pipeline that shares one `xnor_based_ripple_carry_adder16` instance among four requesters. Each requester presents a 16-bit operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the operands, and drives the shared adder. It returns the registered 17-bit sum tagged with the requester ID under a valid/ready response handshake. It sits between the approximate-adder datapath and the client blocks that previously each instantiated their own adder.

---
 rtl/adder16_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_adder16_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder16_rr_arbiter.sv
// Purpose: round-robin share of one 16-bit ripple-carry adder among four requesters, 2-stage pipe.
// Latency: pair accepted at edge E gives rsp_valid_o after edge E+1 (2 edges).
// Backpressure: a stalled response holds S2 and S1; one more pair may enter an empty S1, then ready drops.
module adder16_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [16*NUM_REQ-1:0]   add1_i,
  input  logic [16*NUM_REQ-1:0]   add2_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [16:0]             result_o,
  output logic                    busy_o
);

  typedef struct packed {
    logic [15:0]     a;
    logic [15:0]     b;
    logic [ID_W-1:0] id;
  } s1_t;

  logic            s1_valid;
  s1_t             s1_dat;
  logic [ID_W-1:0] rr_ptr;

  logic            adv1;
  logic            adv2;
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] cand;
  logic            accept;
  logic [16:0]     adder_sum;

  // Pipeline advance: S2 moves when empty or consumed, S1 moves when empty or S2 moves.
  always_comb begin
    adv2 = !rsp_valid_o || rsp_ready_i;
    adv1 = !s1_valid || adv2;
  end

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_ptr;
    cand        = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr + ID_W'(i);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Ready is the one-hot winner, suppressed while S1 cannot advance or while in reset.
  always_comb begin
    req_ready_o = '0;
    accept      = 1'b0;
    if (grant_found && adv1 && !rst_i) begin
      req_ready_o = NUM_REQ'(1) << grant_id;
      accept      = 1'b1;
    end
  end

  xnor_based_ripple_carry_adder16 u_adder (
    .a   (s1_dat.a),
    .b   (s1_dat.b),
    .sum (adder_sum)
  );

  // Pipeline registers and round-robin pointer update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s1_dat      <= '0;
      rsp_valid_o <= 1'b0;
      result_o    <= '0;
      rsp_id_o    <= '0;
      rr_ptr      <= '0;
    end else begin
      if (adv2) begin
        rsp_valid_o <= s1_valid;
        result_o    <= adder_sum;
        rsp_id_o    <= s1_dat.id;
      end
      if (adv1) begin
        s1_valid <= accept;
        if (accept) begin
          s1_dat.a  <= add1_i[{grant_id, 4'b0000} +: 16];
          s1_dat.b  <= add2_i[{grant_id, 4'b0000} +: 16];
          s1_dat.id <= grant_id;
          rr_ptr    <= grant_id + ID_W'(1);
        end
      end
    end
  end

  // Busy whenever either stage holds an entry.
  always_comb begin
    busy_o = s1_valid || rsp_valid_o;
  end

endmodule

// Purpose: 16-bit ripple-carry adder whose sum path is built from XNOR cells, 17-bit result.
// Latency: combinational.
// Backpressure: none.
module xnor_based_ripple_carry_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [16:0] sum
);

  logic [16:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    logic p_n;
    // XNOR of the operands, then XNOR with carry gives the odd-parity sum bit.
    assign p_n         = ~(a[i] ^ b[i]);
    assign sum[i]      = ~(p_n ^ c[i]);
    assign c[i+1]      = (a[i] & b[i]) | (c[i] & ~p_n);
  end

  assign sum[16] = c[16];

endmodule

// File: tb/tb_adder16_rr_arbiter.sv
module tb_adder16_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] a_op [4];
  logic [15:0] b_op [4];
  logic [63:0] add1;
  logic [63:0] add2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [16:0] result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] sum;
  } vec_t;

  vec_t        vecs [6];
  logic [16:0] rr_sum [4];

  always #5 clk = ~clk;

  assign add1 = {a_op[3], a_op[2], a_op[1], a_op[0]};
  assign add2 = {b_op[3], b_op[2], b_op[1], b_op[0]};

  adder16_rr_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .add1_i      (add1),
    .add2_i      (add2),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .result_o    (result),
    .busy_o      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic check_rsp(input string name, input logic [1:0] id, input logic [16:0] sum);
    check({name, "_vld"}, 32'(rsp_valid), 32'd1);
    check({name, "_id"}, 32'(rsp_id), 32'(id));
    check({name, "_sum"}, 32'(result), 32'(sum));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd2, 16'h29AF, 16'h7A1B, 17'h0A3CA};
    vecs[1] = '{2'd0, 16'hFFFF, 16'h0001, 17'h10000};
    vecs[2] = '{2'd1, 16'h8000, 16'h8000, 17'h10000};
    vecs[3] = '{2'd3, 16'h0000, 16'h0000, 17'h00000};
    vecs[4] = '{2'd2, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
    vecs[5] = '{2'd0, 16'h1234, 16'h4321, 17'h05555};

    rr_sum[0] = 17'h02211;
    rr_sum[1] = 17'h09DE4;
    rr_sum[2] = 17'h0FFFF;
    rr_sum[3] = 17'h0FBB8;

    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    a_op[0] = 16'h1100; b_op[0] = 16'h1111;
    a_op[1] = 16'h8116; b_op[1] = 16'h1CCE;
    a_op[2] = 16'h5555; b_op[2] = 16'hAAAA;
    a_op[3] = 16'hFADC; b_op[3] = 16'h00DC;

    // Reset held for 3 edges with every requester valid.
    for (int i = 0; i < 3; i++) begin
      drv();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_vld", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      if (i == 2) rst = 1'b0;
    end

    // Round robin: grants 0,1,2,3,0,1,2,3 with back-to-back responses.
    for (int k = 0; k < 11; k++) begin
      smp();
      if (k < 8) check("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      else       check("rr_ready_idle", 32'(req_ready), 32'd0);
      if (k >= 2 && k < 10) check_rsp("rr_rsp", 2'((k - 2) % 4), rr_sum[(k - 2) % 4]);
      if (k == 10) check("rr_drain", 32'(rsp_valid), 32'd0);
      drv();
      if (k == 7) req_valid = 4'b0000;
    end

    // Single-requester vectors through an idle pipeline.
    for (int v = 0; v < 6; v++) begin
      req_valid          = 4'b0001 << vecs[v].id;
      a_op[vecs[v].id]   = vecs[v].a;
      b_op[vecs[v].id]   = vecs[v].b;
      smp();
      check("vec_ready", 32'(req_ready), 32'(4'b0001 << vecs[v].id));
      check("vec_rsp_early", 32'(rsp_valid), 32'd0);
      drv();
      req_valid = 4'b0000;
      smp();
      check("vec_busy", 32'(busy), 32'd1);
      check("vec_rsp_lat1", 32'(rsp_valid), 32'd0);
      drv();
      smp();
      check_rsp("vec", vecs[v].id, vecs[v].sum);
      drv();
    end

    // Backpressure with requesters 1 and 3; rr_ptr is 1 here.
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    a_op[1] = 16'h0F0F; b_op[1] = 16'hF0F1;
    a_op[3] = 16'h1234; b_op[3] = 16'h0001;
    smp();
    check("bp_c0_ready", 32'(req_ready), 32'b0010);
    check("bp_c0_busy", 32'(busy), 32'd0);
    drv();
    a_op[1] = 16'hABCD; b_op[1] = 16'h1111;
    smp();
    check("bp_c1_ready", 32'(req_ready), 32'b1000);
    check("bp_c1_rsp", 32'(rsp_valid), 32'd0);
    drv();
    a_op[3] = 16'h8001; b_op[3] = 16'h8001;
    for (int c = 2; c < 5; c++) begin
      smp();
      check("bp_hold_ready", 32'(req_ready), 32'd0);
      check("bp_hold_busy", 32'(busy), 32'd1);
      check_rsp("bp_hold", 2'd1, 17'h10000);
      drv();
    end
    rsp_ready = 1'b1;
    smp();
    check_rsp("bp_rel_a", 2'd1, 17'h10000);
    check("bp_rel_ready1", 32'(req_ready), 32'b0010);
    drv();
    req_valid = 4'b1000;
    smp();
    check_rsp("bp_rel_b", 2'd3, 17'h01235);
    check("bp_rel_ready3", 32'(req_ready), 32'b1000);
    drv();
    req_valid = 4'b0000;
    smp();
    check_rsp("bp_rel_c", 2'd1, 17'h0BCDE);
    drv();
    smp();
    check_rsp("bp_rel_d", 2'd3, 17'h10002);
    drv();
    smp();
    check("bp_drain_vld", 32'(rsp_valid), 32'd0);
    check("bp_drain_busy", 32'(busy), 32'd0);
    drv();

    // Pointer wrap: grant 1, then 3 alone, then 0 beats 3.
    req_valid = 4'b0010;
    a_op[1] = 16'h0003; b_op[1] = 16'h0004;
    smp();
    check("wrap_ready1", 32'(req_ready), 32'b0010);
    drv();
    req_valid = 4'b1000;
    a_op[3] = 16'h0001; b_op[3] = 16'h0002;
    smp();
    check("wrap_ready3", 32'(req_ready), 32'b1000);
    drv();
    req_valid = 4'b1001;
    a_op[3] = 16'h7FFF; b_op[3] = 16'h0001;
    a_op[0] = 16'hFFFF; b_op[0] = 16'h8000;
    smp();
    check("wrap_ready0", 32'(req_ready), 32'b0001);
    check_rsp("wrap_r1", 2'd1, 17'h00007);
    drv();
    req_valid = 4'b1000;
    smp();
    check("wrap_ready3b", 32'(req_ready), 32'b1000);
    check_rsp("wrap_r3", 2'd3, 17'h00003);
    drv();
    req_valid = 4'b0000;
    smp();
    check_rsp("wrap_r0", 2'd0, 17'h17FFF);
    drv();
    smp();
    check_rsp("wrap_r3b", 2'd3, 17'h08000);
    drv();

    // Reset mid-flight with both stages full; waiters re-arbitrated from pointer 0.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    a_op[0] = 16'h1111; b_op[0] = 16'h1111;
    smp();
    check("mf_ready0", 32'(req_ready), 32'b0001);
    drv();
    req_valid = 4'b0100;
    a_op[2] = 16'h2222; b_op[2] = 16'h2222;
    smp();
    check("mf_ready2", 32'(req_ready), 32'b0100);
    drv();
    rst       = 1'b1;
    req_valid = 4'b1100;
    a_op[2] = 16'h4000; b_op[2] = 16'hC000;
    a_op[3] = 16'h0005; b_op[3] = 16'h0005;
    smp();
    check("mf_rst_ready", 32'(req_ready), 32'd0);
    check("mf_full_busy", 32'(busy), 32'd1);
    check("mf_full_rsp", 32'(rsp_valid), 32'd1);
    drv();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    smp();
    check("mf_post_busy", 32'(busy), 32'd0);
    check("mf_post_rsp", 32'(rsp_valid), 32'd0);
    check("mf_post_ready", 32'(req_ready), 32'b0100);
    drv();
    req_valid = 4'b0000;
    smp();
    check("mf_no_rsp", 32'(rsp_valid), 32'd0);
    drv();
    smp();
    check_rsp("mf_resume", 2'd2, 17'h10000);
    drv();
    smp();
    check("mf_end", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
